instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage placed directly upstream of the instruction decoder in the MIPS datapath. Owns the fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PC in a small FIFO. Downstream consumes {instruction, pc, pc+4} through valid/ready. Branch/jump/jr redirects flush the buffer and discard any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned).
- DEPTH, 4, instruction buffer entries; power of two, ≥2.

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  taken branch/jump/jr this cycle.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 00).
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  32  request address (= fetch_pc).
- mem_gnt  in  1  request accepted this cycle (valid only while mem_req=1).
- mem_rvalid  in  1  response data valid.
- mem_rdata  in  32  response instruction word.
- inst_valid  out  1  head of buffer available.
- inst_ready  in  1  decoder accepts head.
- inst_data  out  32  instruction word.
- inst_pc  out  32  address of inst_data.
- inst_pc_plus4  out  32  inst_pc + 4 (mod 2^32), for branch adder / jal link.

## Operation
- Registers: fetch_pc, req_pc (address of outstanding request), state, FIFO {data, pc} ×DEPTH, count.
- States: REQ (no request outstanding), WAIT (one outstanding, keep), DROP (one outstanding, discard). At most one outstanding request, except back-to-back issue in WAIT on response cycle.
- mem_req = !reset && !redirect_valid && ((REQ && count<DEPTH) || (WAIT && mem_rvalid && count+1<DEPTH)). Pops are not credited same cycle.
- On mem_req && mem_gnt: req_pc←fetch_pc, fetch_pc←fetch_pc+4 (wraps FFFF_FFFC→0000_0000), next state WAIT.
- WAIT && mem_rvalid: push {mem_rdata, req_pc}; next state WAIT if new grant this cycle, else REQ.
- DROP && mem_rvalid: discard data, next REQ.
- Redirect (priority over everything except reset): fetch_pc←{redirect_pc[31:2],2'b00}; FIFO flushed (count←0, pointers←0); any push that cycle suppressed; inst_valid forced 0 that cycle (no pop). Next state: REQ from REQ; DROP from WAIT/DROP without mem_rvalid; REQ from WAIT/DROP with mem_rvalid (data discarded).
- FIFO: inst_valid = count≠0; pop on inst_valid && inst_ready; simultaneous push+pop keeps count; overflow impossible by construction; pop when empty impossible.
- mem_rvalid in REQ: protocol violation, ignored (no push).

## Timing
- Reset: state REQ, fetch_pc=RESET_PC, count=0, FIFO storage 0. During reset cycle mem_req=0, inst_valid=0, inst_data=0, inst_pc=0, inst_pc_plus4=4; mem_addr=RESET_PC from first cycle after reset.
- Reset mid-operation: in-flight response discarded (state REQ); no stale entries.
- First request: cycle after reset deassert. Grant at cycle N, rvalid at N+k (k≥1) → inst_valid at N+k+1.
- Zero-wait memory (gnt same cycle, rvalid next), DEPTH=4, inst_ready=1: steady throughput one instruction per cycle.
- Redirect at cycle R: first request to redirect_pc at R+1 (from REQ) or cycle after dropped response (from WAIT/DROP).
- Outputs inst_* are registered FIFO head; mem_req/inst_valid have combinational dependency on redirect_valid/mem_rvalid only.

## Structure
- Shared package mips_pkg: fetch_state_t enum {REQ, WAIT, DROP}, WORD_W=32, INSTR_BYTES=4, RESET_PC default constant.
- Sub-module fetch_fifo: synchronous FIFO {data, pc}, width 64, parameter DEPTH, ports push/pop/flush/count/head; flush dominates push.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_0000, inst_ready=1 → inst_pc sequence 0,4,8,… one per cycle, data matches, pc_plus4 = pc+4.
- inst_ready=0 for 10 cycles → exactly DEPTH=4 entries buffered, mem_req drops, no overflow; release → entries 0,4,8,12 in order, fetch resumes at 16.
- Redirect to 32'h0000_0103 while WAIT, response arrives 3 cycles later → response discarded, next mem_addr 32'h0000_0100, inst_pc 0x100 first delivered.
- Redirect coinciding with mem_rvalid and inst_ready → no push, no pop, inst_valid=0 that cycle, next cycle mem_req with redirect address.
- RESET_PC=32'hFFFF_FFF8 → fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; inst_pc_plus4 for 0xFFFF_FFFC is 0.
- Assert reset while WAIT with rvalid pending 2 cycles later → outputs return to reset values, late rvalid ignored, refetch from RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants.
// Used by the fetch stage and its instruction buffer.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {instr, pc} pairs.
// Flush dominates push; storage clears on reset.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  if_id_t                       push_data,
  output if_id_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if_id_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, one outstanding memory read,
// and a small buffer of {instr, pc} feeding the decoder.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH-1);
  localparam logic [WORD_W-1:0] STEP = WORD_W'(INSTR_BYTES);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] req_pc_q, req_pc_d;

  logic [CW-1:0] count;
  if_id_t        head;
  if_id_t        push_data;
  logic          push, pop, gnt, live;

  assign live = !reset && !redirect_valid;

  always_comb begin
    mem_req = 1'b0;
    if (live) begin
      unique case (state_q)
        REQ:     mem_req = count < FULL;
        WAIT:    mem_req = mem_rvalid && (count < FULL_M1);
        default: mem_req = 1'b0;
      endcase
    end
  end

  assign gnt        = mem_req && mem_gnt;
  assign push       = live && (state_q == WAIT) && mem_rvalid;
  assign inst_valid = live && (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push_data  = '{instr: mem_rdata, pc: req_pc_q};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (state_q != REQ) begin
        state_d = mem_rvalid ? REQ : DROP;
      end
    end else begin
      unique case (state_q)
        REQ:     state_d = REQ;
        WAIT:    state_d = mem_rvalid ? REQ : WAIT;
        DROP:    state_d = mem_rvalid ? REQ : DROP;
        default: state_d = REQ;
      endcase
      // back-to-back issue overrides the return to REQ
      if (gnt) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + STEP;
        state_d    = WAIT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .push_data(push_data),
    .head     (head),
    .count    (count)
  );

  assign mem_addr      = fetch_pc_q;
  assign inst_data     = head.instr;
  assign inst_pc       = head.pc;
  assign inst_pc_plus4 = head.pc + STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: stream-level reference model,
// randomized memory/decoder/redirect traffic, directed scenarios.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_rdata = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc, inst_pc_plus4;

  logic        w_req, w_rvalid = 1'b0, w_valid;
  logic [31:0] w_addr, w_rdata = '0, w_data, w_pc, w_p4;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_pc_plus4(inst_pc_plus4)
  );

  instr_fetch_unit #(.RESET_PC(WPC), .DEPTH(DEPTH)) u_wrap (
    .clock(clock), .reset(reset),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .mem_req(w_req), .mem_addr(w_addr), .mem_gnt(1'b1),
    .mem_rvalid(w_rvalid), .mem_rdata(w_rdata),
    .inst_valid(w_valid), .inst_ready(1'b1),
    .inst_data(w_data), .inst_pc(w_pc),
    .inst_pc_plus4(w_p4)
  );

  int total = 0;
  int bad   = 0;

  // stimulus knobs
  logic        k_rst = 1'b1, k_redir = 1'b0, k_ready = 1'b1;
  logic [31:0] k_rpc = '0;
  int          gnt_pct = 100, lat_lo = 1, lat_hi = 1;

  // memory environment
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  int          pepoch = 0;
  logic        w_pend = 1'b0;
  logic [31:0] w_paddr = '0;

  // reference model: expected stream positions and buffer fill
  logic [31:0] mfetch = RPC, mdeliv = RPC;
  int          mcount = 0, epoch = 0, ndeliv = 0;
  logic        rst_prev = 1'b0, wrec = 1'b0;

  logic [31:0] dlv[$], gq[$], wq[$];
  logic [31:0] w_p4fc = 32'hDEAD_BEEF;
  logic        l_req, l_valid, l_rvalid;
  logic [31:0] l_addr;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$],
                                      input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic cyc();
    logic fire, mpop;
    @(negedge clock);
    reset          = k_rst;
    redirect_valid = k_redir;
    redirect_pc    = k_rpc;
    inst_ready     = k_ready;
    mem_gnt        = ($urandom_range(0, 99) < gnt_pct);
    mem_rvalid     = pend && (cnt == 0);
    mem_rdata      = mem_rvalid ? (paddr ^ KEY) : $urandom();
    w_rvalid       = w_pend;
    w_rdata        = w_paddr ^ KEY;
    #1;
    l_req = mem_req; l_valid = inst_valid;
    l_addr = mem_addr; l_rvalid = mem_rvalid;

    if (reset || redirect_valid) begin
      chk("req_blocked", mem_req, 0);
      chk("valid_blocked", inst_valid, 0);
    end else begin
      chk("valid", inst_valid, mcount != 0);
      chk("mem_addr", mem_addr, mfetch);
    end
    if (reset && rst_prev) begin
      chk("rst_data", inst_data, 0);
      chk("rst_pc", inst_pc, 0);
      chk("rst_pc4", inst_pc_plus4, 4);
      chk("rst_req", mem_req, 0);
    end
    if (inst_valid) begin
      chk("inst_pc", inst_pc, mdeliv);
      chk("inst_data", inst_data, mdeliv ^ KEY);
      chk("inst_pc4", inst_pc_plus4, mdeliv + 32'd4);
    end
    if (w_valid && !reset) begin
      chk("w_data", w_data, w_pc ^ KEY);
      chk("w_pc4", w_p4, w_pc + 32'd4);
    end

    fire = mem_req && mem_gnt;
    mpop = (mcount != 0) && inst_ready;
    if (reset) begin
      mfetch = RPC; mdeliv = RPC; mcount = 0; epoch++;
    end else if (redirect_valid) begin
      mfetch = {redirect_pc[31:2], 2'b00};
      mdeliv = mfetch; mcount = 0; epoch++;
    end else begin
      if (mem_rvalid && pepoch == epoch) mcount++;
      if (mpop) begin
        mcount--; mdeliv += 32'd4; ndeliv++;
        dlv.push_back(inst_pc);
      end
      if (fire) begin
        mfetch += 32'd4;
        gq.push_back(mem_addr);
      end
    end

    if (mem_rvalid) pend = 1'b0;
    else if (pend) cnt--;
    if (fire && !reset) begin
      pend = 1'b1;
      cnt = $urandom_range(lat_lo, lat_hi) - 1;
      paddr = mem_addr;
      pepoch = epoch;
    end

    w_pend = w_req; w_paddr = w_addr;
    if (wrec && w_req && !reset && wq.size() < 3) wq.push_back(w_addr);
    if (w_valid && !reset && w_pc == 32'hFFFF_FFFC) w_p4fc = w_p4;
    rst_prev = reset;
  endtask

  task automatic do_reset(input int n);
    k_rst = 1'b1; k_redir = 1'b0;
    repeat (n) cyc();
    k_rst = 1'b0;
    dlv.delete(); gq.delete(); ndeliv = 0;
  endtask

  int rst_hold;

  initial begin
    // zero-wait streaming and wrap-around instance
    gnt_pct = 100; lat_lo = 1; lat_hi = 1; k_ready = 1'b1;
    do_reset(3);
    wq.delete(); wrec = 1'b1;
    repeat (20) cyc();
    wrec = 1'b0;
    chk("throughput", ndeliv, 18);
    chk("first_pc", qat(dlv, 0), 32'h0);
    chk("wrap_req0", qat(wq, 0), 32'hFFFF_FFF8);
    chk("wrap_req1", qat(wq, 1), 32'hFFFF_FFFC);
    chk("wrap_req2", qat(wq, 2), 32'h0000_0000);
    chk("wrap_pc4", w_p4fc, 32'h0);

    // decoder stall fills the buffer exactly
    do_reset(3);
    k_ready = 1'b0;
    repeat (10) cyc();
    chk("stall_req", l_req, 0);
    chk("stall_addr", l_addr, 32'h10);
    chk("stall_grants", gq.size(), DEPTH);
    gq.delete();
    k_ready = 1'b1;
    repeat (6) cyc();
    for (int i = 0; i < 4; i++)
      chk("stall_order", qat(dlv, i), 32'(i * 4));
    chk("resume_addr", qat(gq, 0), 32'h10);

    // redirect while a slow response is outstanding
    lat_lo = 4; lat_hi = 4;
    do_reset(3);
    cyc();
    dlv.delete(); gq.delete();
    k_redir = 1'b1; k_rpc = 32'h0000_0103;
    cyc();
    k_redir = 1'b0;
    repeat (15) cyc();
    chk("rd_first_req", qat(gq, 0), 32'h100);
    chk("rd_first_pc", qat(dlv, 0), 32'h100);

    // redirect on a response cycle with the decoder ready
    lat_lo = 1; lat_hi = 1;
    do_reset(3);
    repeat (6) cyc();
    k_redir = 1'b1; k_rpc = 32'h0000_0200;
    cyc();
    k_redir = 1'b0;
    chk("co_rvalid", l_rvalid, 1);
    chk("co_valid", l_valid, 0);
    chk("co_req", l_req, 0);
    cyc();
    chk("co_next_req", l_req, 1);
    chk("co_next_addr", l_addr, 32'h200);

    // reset while a response is still pending
    lat_lo = 3; lat_hi = 3;
    do_reset(3);
    cyc();
    k_rst = 1'b1;
    repeat (4) cyc();
    k_rst = 1'b0;
    dlv.delete(); gq.delete();
    repeat (10) cyc();
    chk("mr_first_req", qat(gq, 0), RPC);
    chk("mr_first_pc", qat(dlv, 0), RPC);

    // randomized traffic
    lat_lo = 1; lat_hi = 4; rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) gnt_pct = $urandom_range(30, 100);
      if (rst_hold > 0) begin
        k_rst = 1'b1; rst_hold--;
      end else if ($urandom_range(0, 199) == 0) begin
        k_rst = 1'b1; rst_hold = 3;
      end else begin
        k_rst = 1'b0;
      end
      k_redir = !k_rst && ($urandom_range(0, 29) == 0);
      k_rpc   = $urandom();
      k_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    k_rst = 1'b0; k_redir = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
